// File: rtl/pwl_act_pipe.sv
// Pipelined piecewise-linear activation unit: sigmoid, tanh, ReLU or identity
// selected per sample by a 2-bit mode tag. Three register stages with
// valid/ready backpressure; bubbles collapse so an empty stage always refills.
module pwl_act_pipe #(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [1:0]               in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [1:0]               out_mode
);

    if (FRAC_W < 5 || FRAC_W > DATA_W - 4) begin : g_bad_frac
        $error("pwl_act_pipe: FRAC_W must satisfy 5 <= FRAC_W <= DATA_W-4");
    end

    // Working width leaves headroom for 8*a and 2p-ONE without overflow.
    localparam int AW = DATA_W + 4;

    localparam logic [1:0] MODE_SIG  = 2'd0;
    localparam logic [1:0] MODE_TANH = 2'd1;
    localparam logic [1:0] MODE_RELU = 2'd2;

    localparam logic signed [AW-1:0] ONE      = AW'(1) <<< FRAC_W;
    localparam logic signed [AW-1:0] ONE_HALF = ONE >>> 1;
    localparam logic signed [AW-1:0] FIVE_ONE = AW'(5) * ONE;
    localparam logic signed [AW-1:0] K19_ONE  = AW'(19) * ONE;
    localparam logic signed [AW-1:0] OFF_MID  = (AW'(5) * ONE) >>> 3;
    localparam logic signed [AW-1:0] OFF_HI   = (AW'(27) * ONE) >>> 5;

    localparam logic signed [DATA_W+1:0] MAG_MAX = {3'b000, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0]     OUT_MAX = {{(AW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [AW-1:0]     OUT_MIN = {{(AW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // |v| clipped to the largest positive DATA_W value; the extra bit keeps
    // the negation of the most negative 2x exact.
    function automatic logic signed [DATA_W-1:0] abs_sat(input logic signed [DATA_W:0] v);
        logic signed [DATA_W+1:0] w;
        w = {v[DATA_W], v};
        if (w < 0) w = -w;
        if (w > MAG_MAX) w = MAG_MAX;
        return w[DATA_W-1:0];
    endfunction

    // Positive-half sigmoid approximation; thresholds compared exactly by
    // scaling a instead of dividing the constant.
    function automatic logic signed [AW-1:0] plan_pos(input logic signed [DATA_W-1:0] a);
        logic signed [AW-1:0] aw;
        aw = {{4{a[DATA_W-1]}}, a};
        if (aw >= FIVE_ONE)            return ONE;
        else if ((aw <<< 3) >= K19_ONE) return (aw >>> 5) + OFF_HI;
        else if (aw >= ONE)             return (aw >>> 3) + OFF_MID;
        else                            return (aw >>> 2) + ONE_HALF;
    endfunction

    // Clamp a working-width result into the signed output range.
    function automatic logic signed [DATA_W-1:0] sat_out(input logic signed [AW-1:0] v);
        logic signed [AW-1:0] c;
        c = v;
        if (c > OUT_MAX) c = OUT_MAX;
        else if (c < OUT_MIN) c = OUT_MIN;
        return c[DATA_W-1:0];
    endfunction

    logic                     vld_p0, vld_p1, vld_p2;
    logic                     load_p0, load_p1, load_p2;
    logic [1:0]               mode_p0, mode_p1, mode_p2;
    logic                     sign_p0, sign_p1;
    logic signed [DATA_W-1:0] mag_p0;
    logic signed [DATA_W-1:0] x_p0, x_p1;
    logic signed [AW-1:0]     p_p1;
    logic signed [DATA_W-1:0] y_p2;
    logic signed [DATA_W:0]   x2_in;
    logic signed [AW-1:0]     xw, tw, y_wide;

    // A stage loads when it is empty or its successor is loading.
    assign load_p2  = !vld_p2 || out_ready;
    assign load_p1  = !vld_p1 || load_p2;
    assign load_p0  = !vld_p0 || load_p1;
    assign in_ready = load_p0 && !rst;

    assign x2_in = (in_mode == MODE_TANH) ? {in_data, 1'b0} : {in_data[DATA_W-1], in_data};

    // S1: register mode, sign, clipped magnitude and the raw sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            mode_p0 <= '0;
            sign_p0 <= 1'b0;
            mag_p0  <= '0;
            x_p0    <= '0;
        end else if (load_p0) begin
            vld_p0  <= in_valid;
            mode_p0 <= in_mode;
            sign_p0 <= in_data[DATA_W-1];
            mag_p0  <= abs_sat(x2_in);
            x_p0    <= in_data;
        end
    end

    // S2: evaluate the positive-half curve, carry sign, mode and raw sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            mode_p1 <= '0;
            sign_p1 <= 1'b0;
            p_p1    <= '0;
            x_p1    <= '0;
        end else if (load_p1) begin
            vld_p1  <= vld_p0;
            mode_p1 <= mode_p0;
            sign_p1 <= sign_p0;
            p_p1    <= plan_pos(mag_p0);
            x_p1    <= x_p0;
        end
    end

    // S3 combinational: reflect the half-curve or pass the sample per mode.
    always_comb begin
        xw     = {{4{x_p1[DATA_W-1]}}, x_p1};
        tw     = (p_p1 <<< 1) - ONE;
        y_wide = xw;
        case (mode_p1)
            MODE_SIG:  y_wide = sign_p1 ? ONE - p_p1 : p_p1;
            MODE_TANH: y_wide = sign_p1 ? -tw : tw;
            MODE_RELU: y_wide = sign_p1 ? '0 : xw;
            default:   y_wide = xw;
        endcase
    end

    // S3: output register; holds while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p2  <= 1'b0;
            mode_p2 <= '0;
            y_p2    <= '0;
        end else if (load_p2) begin
            vld_p2  <= vld_p1;
            mode_p2 <= mode_p1;
            y_p2    <= sat_out(y_wide);
        end
    end

    assign out_valid = vld_p2;
    assign out_data  = y_p2;
    assign out_mode  = mode_p2;

endmodule

// File: tb/tb_pwl_act_pipe.sv
// Self-checking bench for pwl_act_pipe: directed vectors, stall/bubble
// behaviour, asynchronous reset and a long random valid/ready stream.
module tb_pwl_act_pipe;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    logic                     clk = 1'b0;
    logic                     rst = 1'b0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data = '0;
    logic [1:0]               in_mode = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic signed [DATA_W-1:0] out_data;
    logic [1:0]               out_mode;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int acc_x[$], acc_m[$], acc_t[$];
    int out_d[$], out_m[$], out_t[$];

    pwl_act_pipe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Inputs change just after the rising edge, so the values seen here are
    // exactly those the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                acc_x.push_back(int'(in_data));
                acc_m.push_back(int'(in_mode));
                acc_t.push_back(cyc);
            end
            if (out_valid && out_ready) begin
                out_d.push_back(int'(out_data));
                out_m.push_back(int'(out_mode));
                out_t.push_back(cyc);
            end
        end
    end

    // Reference: the activation rules evaluated with plain integer arithmetic.
    function automatic int model(input int x, input int mode);
        int one, a, p, t, y, maxv, minv;
        one  = 1 << FRAC_W;
        maxv = (1 << (DATA_W - 1)) - 1;
        minv = -(1 << (DATA_W - 1));
        a = (mode == 1) ? 2 * x : x;
        if (a < 0) a = -a;
        if (a > maxv) a = maxv;
        if (a >= 5 * one)        p = one;
        else if (8 * a >= 19 * one) p = a / 32 + (27 * one) / 32;
        else if (a >= one)       p = a / 8 + (5 * one) / 8;
        else                     p = a / 4 + one / 2;
        t = 2 * p - one;
        case (mode)
            0:       y = (x < 0) ? one - p : p;
            1:       y = (x < 0) ? -t : t;
            2:       y = (x < 0) ? 0 : x;
            default: y = x;
        endcase
        if (y > maxv) y = maxv;
        if (y < minv) y = minv;
        return y;
    endfunction

    function automatic int rand_x();
        logic signed [DATA_W-1:0] r;
        int pick[10] = '{-32768, 32767, 0, 256, -256, 1280, 1279, 608, 607, -608};
        case ($urandom_range(0, 3))
            0: begin r = DATA_W'($urandom); return int'(r); end
            1: return int'($urandom_range(0, 3000)) - 1500;
            2: return pick[$urandom_range(0, 9)];
            default: return int'($urandom_range(0, 600)) - 300;
        endcase
    endfunction

    task automatic clear_q();
        acc_x.delete(); acc_m.delete(); acc_t.delete();
        out_d.delete(); out_m.delete(); out_t.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #2;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL rst_out_data: got %0d want 0", out_data); end
        total++; if (out_mode !== 2'd0) begin bad++; $display("FAIL rst_out_mode: got %0d want 0", out_mode); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        step();
    endtask

    task automatic test_sigmoid();
        int xs[6] = '{0, 256, -256, 640, 1280, -32768};
        int ys[6] = '{128, 192, 64, 236, 256, 0};
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(xs[i]); in_mode = 2'd0;
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && out_d.size() < 6; k++) step();
        total++;
        if (out_d.size() !== 6 || acc_t.size() !== 6) begin
            bad++; $display("FAIL sig_count: got %0d outputs want 6", out_d.size());
        end
        for (int i = 0; i < out_d.size() && i < 6 && i < acc_t.size(); i++) begin
            total++;
            if (out_d[i] !== ys[i] || out_m[i] !== 0) begin
                bad++; $display("FAIL sig_out[%0d]: got %0d/mode %0d want %0d/mode 0", i, out_d[i], out_m[i], ys[i]);
            end
            total++;
            if (out_t[i] - acc_t[i] !== 3) begin
                bad++; $display("FAIL sig_latency[%0d]: got %0d want 3", i, out_t[i] - acc_t[i]);
            end
        end
    endtask

    task automatic test_tanh();
        int xs[4] = '{0, 128, -128, 32767};
        int ys[4] = '{0, 128, -128, 256};
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(xs[i]); in_mode = 2'd1;
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && out_d.size() < 4; k++) step();
        total++;
        if (out_d.size() !== 4) begin bad++; $display("FAIL tanh_count: got %0d want 4", out_d.size()); end
        for (int i = 0; i < out_d.size() && i < 4; i++) begin
            total++;
            if (out_d[i] !== ys[i] || out_m[i] !== 1) begin
                bad++; $display("FAIL tanh_out[%0d]: got %0d/mode %0d want %0d/mode 1", i, out_d[i], out_m[i], ys[i]);
            end
        end
    endtask

    task automatic test_mixed();
        int xs[5] = '{-300, 0, 300, 0, -300};
        int ms[5] = '{2, 0, 2, 0, 3};
        int ys[5] = '{0, 128, 300, 128, -300};
        clear_q();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(xs[i]); in_mode = 2'(ms[i]);
            step();
        end
        in_valid = 1'b0;
        for (int k = 0; k < 20 && out_d.size() < 5; k++) step();
        total++;
        if (out_d.size() !== 5) begin bad++; $display("FAIL mix_count: got %0d want 5", out_d.size()); end
        for (int i = 0; i < out_d.size() && i < 5; i++) begin
            total++;
            if (out_d[i] !== ys[i] || out_m[i] !== ms[i]) begin
                bad++; $display("FAIL mix_out[%0d]: got %0d/mode %0d want %0d/mode %0d", i, out_d[i], out_m[i], ys[i], ms[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        int xs[8];
        int sent = 0;
        bit saw_full = 1'b0;
        bit have_hold = 1'b0;
        logic signed [DATA_W-1:0] hold = '0;
        for (int i = 0; i < 8; i++) xs[i] = int'($urandom_range(0, 4000)) - 2000;
        clear_q();
        for (int i = 0; i < 40; i++) begin
            out_ready = !(i >= 4 && i <= 9);
            in_valid  = (sent < 8);
            if (sent < 8) begin in_data = DATA_W'(xs[sent]); in_mode = 2'd0; end
            @(negedge clk);
            if (!out_ready && out_valid) begin
                if (have_hold) begin
                    total++;
                    if (out_data !== hold) begin bad++; $display("FAIL bp_hold: got %0d want %0d", out_data, hold); end
                end else begin
                    hold = out_data; have_hold = 1'b1;
                end
            end
            if (in_valid && !in_ready) begin
                saw_full = 1'b1;
                total++;
                if (acc_x.size() - out_d.size() !== 3) begin
                    bad++; $display("FAIL bp_occupancy: got %0d want 3", acc_x.size() - out_d.size());
                end
            end
            if (in_valid && in_ready) sent++;
            step();
        end
        in_valid = 1'b0;
        total++;
        if (saw_full !== 1'b1) begin bad++; $display("FAIL bp_in_ready_drop: got %0b want 1", saw_full); end
        total++;
        if (out_d.size() !== 8) begin bad++; $display("FAIL bp_count: got %0d want 8", out_d.size()); end
        for (int i = 0; i < out_d.size() && i < 8; i++) begin
            total++;
            if (out_d[i] !== model(xs[i], 0)) begin
                bad++; $display("FAIL bp_out[%0d]: got %0d want %0d", i, out_d[i], model(xs[i], 0));
            end
        end
    endtask

    task automatic test_bubble();
        int xs[4] = '{256, -256, 640, 0};
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(xs[i]); in_mode = 2'd0;
            @(negedge clk);
            total++;
            if (in_ready !== (i < 3)) begin
                bad++; $display("FAIL bubble_in_ready[%0d]: got %0b want %0b", i, in_ready, (i < 3));
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && out_d.size() < 3; k++) step();
        repeat (3) step();
        total++;
        if (out_d.size() !== 3) begin bad++; $display("FAIL bubble_count: got %0d want 3", out_d.size()); end
        for (int i = 0; i < out_d.size() && i < 3; i++) begin
            total++;
            if (out_d[i] !== model(xs[i], 0)) begin
                bad++; $display("FAIL bubble_out[%0d]: got %0d want %0d", i, out_d[i], model(xs[i], 0));
            end
        end
    endtask

    task automatic test_reset_mid();
        int xs[3] = '{-1280, 300, 1500};
        clear_q();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_data = DATA_W'(xs[i]); in_mode = 2'd0;
            step();
        end
        in_valid = 1'b0;
        total++;
        if (out_valid !== 1'b1) begin bad++; $display("FAIL rmid_full: got %0b want 1", out_valid); end
        #2 rst = 1'b1;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid_out_valid: got %0b want 0", out_valid); end
        total++; if (out_data !== '0) begin bad++; $display("FAIL rmid_out_data: got %0d want 0", out_data); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rmid_in_ready: got %0b want 0", in_ready); end
        @(posedge clk);
        #2 rst = 1'b0;
        clear_q();
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 16'sd256; in_mode = 2'd0;
        step();
        in_valid = 1'b0;
        repeat (10) step();
        total++;
        if (out_d.size() !== 1 || acc_t.size() !== 1) begin
            bad++; $display("FAIL rmid_count: got %0d outputs want 1", out_d.size());
        end else begin
            total++;
            if (out_d[0] !== 192) begin bad++; $display("FAIL rmid_out: got %0d want 192", out_d[0]); end
            total++;
            if (out_t[0] - acc_t[0] !== 3) begin bad++; $display("FAIL rmid_latency: got %0d want 3", out_t[0] - acc_t[0]); end
        end
    endtask

    task automatic test_random();
        int n = 10000;
        int sent = 0;
        int guard = 0;
        bit took;
        clear_q();
        while ((sent < n || out_d.size() < n) && guard < 60000) begin
            guard++;
            if (!in_valid && sent < n && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = DATA_W'(rand_x());
                in_mode  = 2'($urandom_range(0, 3));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            took = in_valid && in_ready;
            step();
            if (took) begin sent++; in_valid = 1'b0; end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (5) step();
        total++;
        if (out_d.size() !== n || acc_x.size() !== n) begin
            bad++; $display("FAIL rand_count: got %0d outputs %0d accepted want %0d", out_d.size(), acc_x.size(), n);
        end
        for (int i = 0; i < out_d.size() && i < acc_x.size(); i++) begin
            total++;
            if (out_d[i] !== model(acc_x[i], acc_m[i]) || out_m[i] !== acc_m[i]) begin
                bad++;
                $display("FAIL rand_out[%0d]: x=%0d mode=%0d got %0d/mode %0d want %0d/mode %0d",
                         i, acc_x[i], acc_m[i], out_d[i], out_m[i], model(acc_x[i], acc_m[i]), acc_m[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sigmoid();
        test_tanh();
        test_mixed();
        test_backpressure();
        test_bubble();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pwl_act_pipe.md
Name: pwl_act_pipe

Overview:
- Parametrised, pipelined piecewise-linear activation unit; successor to the fixed 16-bit single-cycle 3-segment sigmoid.
- Computes sigmoid, tanh, ReLU or identity per sample, selected by a per-sample mode tag.
- Uses a 3-stage pipeline with valid/ready backpressure on both sides.
- Sits between the MAC/accumulator output and the layer writeback path in the generator and discriminator datapaths.

Parameters:
- DATA_W, 16: signed two's-complement width of input and output samples.
- FRAC_W, 8: fractional bits, fixed-point Q(DATA_W-FRAC_W).FRAC_W. Legal range is 5 <= FRAC_W <= DATA_W-4; elaboration error outside this range.

Ports:
- clk, in, 1: rising-edge clock.
- rst, in, 1: asynchronous, active-high reset.
- in_valid, in, 1: input sample valid.
- in_ready, out, 1: unit accepts a sample this cycle.
- in_data, in, DATA_W: signed input x.
- in_mode, in, 2: 0 sigmoid, 1 tanh, 2 ReLU, 3 identity.
- out_valid, out, 1: output sample valid.
- out_ready, in, 1: downstream accepts a sample.
- out_data, out, DATA_W: signed result y.
- out_mode, out, 2: mode tag travelling with the result.

Behaviour:
- Reset (async assert, sync release): all stage valid bits cleared, all data/mode registers 0. While rst is high: out_valid=0, out_data=0, out_mode=0, in_ready=0. In-flight samples are discarded, not flushed.
- Transfers: input transfer on in_valid && in_ready; output transfer on out_valid && out_ready.
- Stall logic: stages S1, S2, S3 each have a valid bit. Stage k loads when it is empty or stage k+1 loads; S3 loads when it is empty or out_ready=1. in_ready = S1 load condition, combinational, no dependency on in_valid. Bubbles collapse.
- Latency: exactly 3 cycles with no stall, accepted at edge N and out_valid at edge N+3. Throughput is 1 sample/clock with out_ready held high.
- Data stability: out_data and out_mode hold stable while out_valid && !out_ready.
- Input ordering: samples leave in acceptance order; no drops or duplicates.
- Constant: ONE = 1<<FRAC_W.
- S1 (input conditioning):
  - Register mode and sign s = x<0.
  - For tanh, use x2 = 2x computed in DATA_W+1 bits; otherwise x2 = x.
  - a = |x2|, saturated to 2^(DATA_W-1)-1. The most negative input maps to max.
- S2 (PLAN positive half, shift-and-add, truncating shifts):
  - a >= 5*ONE: p = ONE.
  - a >= 19*ONE/8: p = (a>>5) + 27*ONE/32.
  - a >= ONE: p = (a>>3) + 5*ONE/8.
  - else: p = (a>>2) + ONE/2.
  - Comparisons are against exact constants.
- S3 (reflection and output):
  - sigmoid: y = s ? ONE-p : p.
  - tanh: t = 2p-ONE, then y = s ? -t : t.
  - ReLU: y = s ? 0 : x.
  - identity: y = x.
  - S2 and S3 carry x through for ReLU and identity.
  - Result is saturated to DATA_W signed. Sigmoid stays within [0, ONE] and tanh within [-ONE, ONE].
- Simultaneous accept and emit with all stages full and out_ready=1: all stages advance, with no bubble and no loss.
- Mode change between consecutive samples is legal every cycle, with no pipeline flush.

Test Plan:
- Sigmoid with DATA_W=16, FRAC_W=8, out_ready=1, back-to-back inputs 0, 256, -256, 640, 1280, -32768 -> outputs 128, 192, 64, 236, 256, 0. Each appears 3 cycles after acceptance, one per cycle.
- Tanh with inputs 0, 128, -128, 32767 -> outputs 0, 128, -128, 256. out_mode=1 on each output.
- ReLU/identity with inputs -300 (mode 2), 300 (mode 2), -300 (mode 3) -> outputs 0, 300, -300. Modes are interleaved with sigmoid sample 0 (expected output 128), with no cross-contamination.
- Backpressure: stream 8 sigmoid samples, hold out_ready=0 for cycles 4-9.
  - After 3 samples are buffered, in_ready goes 0.
  - out_data holds stable while stalled.
  - After release, all 8 results appear in order; none lost or duplicated.
  - A random in_valid/out_ready scoreboard run of 10k samples must match the golden model.
- Bubble collapse: insert one valid sample into an empty pipe with out_ready=0 -> in_ready remains 1 for the next 2 accepts, then drops to 0.
- Reset mid-stream: assert rst asynchronously between edges with 3 samples in flight -> out_valid drops immediately and out_data=0. After release, no stale sample emerges; the next accepted input (256 in sigmoid mode) yields 192 after 3 cycles.
